// File: rtl/msp430_ram_arbiter.sv
// msp430_ram_arbiter: two-port (instruction fetch IF / data DT) front-end for the
// single-port msp430_ram. Reads return one cycle after accept through a registered
// response stage.
// Ports: ram_clk/ram_rst_n (async active-low); IF port: if_valid/if_ready/if_addr in,
// if_rsp_valid/if_rsp_data/if_rsp_err out. DT port: dt_valid/dt_ready/dt_addr/dt_we/
// dt_be/dt_wdata in, dt_rsp_valid/dt_rsp_data/dt_rsp_err out. RAM side: ram_addr/
// ram_cen/ram_wen/ram_din out, ram_dout in.
// Build option: define MSP430_RAM_ARB_RR_EN for round-robin arbitration on contention;
// otherwise DT has fixed priority over IF.
// No response backpressure: a granted request is accepted on the next edge.
module msp430_ram_arbiter #(
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int MEM_SIZE = 256
) (
  input  logic          ram_clk,
  input  logic          ram_rst_n,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic [AW:0]   if_addr,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  output logic          if_rsp_err,
  input  logic          dt_valid,
  output logic          dt_ready,
  input  logic [AW:0]   dt_addr,
  input  logic          dt_we,
  input  logic [1:0]    dt_be,
  input  logic [DW-1:0] dt_wdata,
  output logic          dt_rsp_valid,
  output logic [DW-1:0] dt_rsp_data,
  output logic          dt_rsp_err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_cen,
  output logic [1:0]    ram_wen,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [31:0] WORDS = 32'(MEM_SIZE / 2);

  logic          rdy_q;
  logic          gnt_if, gnt_dt, acc, acc_wr, in_range;
  logic [AW-1:0] sel_addr;
  logic          p_vld, p_dt, p_rd, p_err;
  logic [DW-1:0] rsp_word, if_data_q, dt_data_q;

  // Byte-address bit 0 selects nothing in a word-wide RAM.
  logic unused_addr_lsb;
  assign unused_addr_lsb = if_addr[0] ^ dt_addr[0];

  // Holds grants off for the first cycle after reset release.
  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) rdy_q <= 1'b0;
    else            rdy_q <= 1'b1;
  end

`ifdef MSP430_RAM_ARB_RR_EN
  // last_dt=1 means DT won the previous accept; reset value lets IF win the first tie.
  logic last_dt;

  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) last_dt <= 1'b1;
    else if (acc)   last_dt <= gnt_dt;
  end

  always_comb begin
    gnt_if = 1'b0;
    gnt_dt = 1'b0;
    if (rdy_q) begin
      if (if_valid && dt_valid) begin
        gnt_if = last_dt;
        gnt_dt = !last_dt;
      end else begin
        gnt_if = if_valid;
        gnt_dt = dt_valid;
      end
    end
  end
`else
  assign gnt_dt = rdy_q & dt_valid;
  assign gnt_if = rdy_q & if_valid & ~dt_valid;
`endif

  assign if_ready = gnt_if;
  assign dt_ready = gnt_dt;
  assign acc      = gnt_if | gnt_dt;
  assign acc_wr   = gnt_dt & dt_we;
  assign sel_addr = gnt_dt ? dt_addr[AW:1] : if_addr[AW:1];
  assign in_range = (32'(sel_addr) < WORDS);

  // Out-of-range accesses and empty-byte-enable writes are accepted but never reach the RAM.
  assign ram_addr = sel_addr;
  assign ram_din  = dt_wdata;
  assign ram_cen  = ~(acc & in_range & ~(acc_wr & (dt_be == 2'b00)));
  assign ram_wen  = (acc & in_range & acc_wr) ? ~dt_be : 2'b11;

  // Response stage: remembers who was served, whether it was a read, and range status.
  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      p_vld <= 1'b0;
      p_dt  <= 1'b0;
      p_rd  <= 1'b0;
      p_err <= 1'b0;
    end else begin
      p_vld <= acc;
      p_dt  <= gnt_dt;
      p_rd  <= ~acc_wr;
      p_err <= ~in_range;
    end
  end

  // RAM output is only valid in the response cycle, so data is passed through then and
  // held in a register afterwards.
  assign rsp_word     = p_err ? '0 : ram_dout;
  assign if_rsp_valid = p_vld & ~p_dt & p_rd;
  assign dt_rsp_valid = p_vld &  p_dt & p_rd;
  assign if_rsp_err   = if_rsp_valid & p_err;
  assign dt_rsp_err   = p_vld & p_dt & p_err;
  assign if_rsp_data  = if_rsp_valid ? rsp_word : if_data_q;
  assign dt_rsp_data  = dt_rsp_valid ? rsp_word : dt_data_q;

  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      if_data_q <= '0;
      dt_data_q <= '0;
    end else begin
      if (if_rsp_valid) if_data_q <= rsp_word;
      if (dt_rsp_valid) dt_data_q <= rsp_word;
    end
  end

endmodule
